// File: rtl/pc_pkg.sv
// Shared types and helpers for the fetch program-counter block.
package pc_pkg;

  // Bytes per MIPS instruction; sequential fetch and call return addresses step by this.
  localparam int INSTR_BYTES = 4;

  // Widest address the alignment helper handles; callers zero-extend into it.
  localparam int MAX_ADDR_W = 64;

  // Which source drives the next fetch address.
  typedef enum logic [2:0] {
    PC_SRC_SEQ,
    PC_SRC_JUMP,
    PC_SRC_BRANCH,
    PC_SRC_EXC,
    PC_SRC_HOLD
  } pc_src_e;

  // Result of aligning a redirect target: word-aligned address plus misalignment flag.
  typedef struct packed {
    logic [MAX_ADDR_W-1:0] addr;
    logic                  err;
  } align_t;

  // Force a target onto a word boundary and report whether it was misaligned.
  function automatic align_t align_target(input logic [MAX_ADDR_W-1:0] target);
    align_t res;
    res.addr = {target[MAX_ADDR_W-1:2], 2'b00};
    res.err  = |target[1:0];
    return res;
  endfunction

endpackage

// File: rtl/pc_gen_ras.sv
// Return-address stack: circular buffer of predicted JR $ra targets.
// A push onto a full stack overwrites the oldest entry; the count saturates.
module return_addr_stack #(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned RAS_DEPTH = 4
) (
  input  logic              clock__i,
  input  logic              reset__i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [ADDR_W-1:0] push_data_i,
  output logic [ADDR_W-1:0] top_o,
  output logic              valid_o
);

  localparam int unsigned PTR_W = $clog2(RAS_DEPTH);
  localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(RAS_DEPTH);

  logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              wr_en;
  logic [PTR_W-1:0]  wr_idx;

  // Next pointer/count and write slot for push, pop or replace-top.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    ptr_d  = ptr_q;
    cnt_d  = cnt_q;
    wr_en  = 1'b0;
    wr_idx = ptr_q;
    if (push_i && pop_i) begin
      // Replace the top entry in place; an empty stack gains that single entry.
      wr_en = 1'b1;
      if (cnt_q == '0) cnt_d = CNT_W'(1);
    end else if (push_i) begin
      // The pointer wraps naturally, so a full stack overwrites its oldest slot.
      ptr_d  = ptr_q + PTR_W'(1);
      wr_idx = ptr_q + PTR_W'(1);
      wr_en  = 1'b1;
      if (cnt_q != FULL_CNT) cnt_d = cnt_q + CNT_W'(1);
    end else if (pop_i && (cnt_q != '0)) begin
      ptr_d = ptr_q - PTR_W'(1);
      cnt_d = cnt_q - CNT_W'(1);
    end
  end

  // Stack pointer and occupancy registers.
  always_ff @(posedge clock__i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (reset__i) begin
      ptr_q <= '0;
      cnt_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage.
  always_ff @(posedge clock__i) begin
    // NOTE: storage is not reset; the zero count masks stale entries.
    if (wr_en && !reset__i) mem_q[wr_idx] <= push_data_i;
  end

  assign valid_o = (cnt_q != '0);
  assign top_o   = valid_o ? mem_q[ptr_q] : '0;

endmodule

// File: rtl/pc_gen.sv
// Fetch program counter: next-PC priority mux, PC and EPC registers,
// misaligned-target flag, and the return-address stack feeding decode.
module pc_gen
  import pc_pkg::*;
#(
  parameter int unsigned       ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter logic [ADDR_W-1:0] EXC_VECTOR   = ADDR_W'(32'h8000_0180),
  parameter int unsigned       RAS_DEPTH    = 4
) (
  input  logic              clock__i,
  input  logic              reset__i,
  input  logic              stall__i,
  output logic              imem_req__o,
  input  logic              imem_ack__i,
  output logic [ADDR_W-1:0] pc__o,
  input  logic              jump__i,
  input  logic [ADDR_W-1:0] jump_target__i,
  input  logic              branch__i,
  input  logic [ADDR_W-1:0] branch_target__i,
  input  logic              exc__i,
  input  logic [ADDR_W-1:0] exc_pc__i,
  output logic [ADDR_W-1:0] epc__o,
  input  logic              call__i,
  input  logic [ADDR_W-1:0] call_pc__i,
  input  logic              ret__i,
  output logic [ADDR_W-1:0] ras_target__o,
  output logic              ras_valid__o,
  output logic              addr_err__o
);

  pc_src_e           pc_src;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] epc_q, epc_d;
  logic              addr_err_q, addr_err_d;
  logic [ADDR_W-1:0] tgt_raw;
  align_t            tgt_aligned;
  logic              ras_push, ras_pop;

  // Pick the next-PC source: exception > branch > jump > hold > sequential.
  always_comb begin
    pc_src = PC_SRC_SEQ;
    if (exc__i)                        pc_src = PC_SRC_EXC;
    else if (branch__i)                pc_src = PC_SRC_BRANCH;
    else if (jump__i)                  pc_src = PC_SRC_JUMP;
    else if (stall__i || !imem_ack__i) pc_src = PC_SRC_HOLD;
  end

  // Form next PC/EPC; only the winning jump or branch target can raise the alignment flag.
  always_comb begin
    tgt_raw     = (pc_src == PC_SRC_BRANCH) ? branch_target__i : jump_target__i;
    tgt_aligned = align_target(MAX_ADDR_W'(tgt_raw));
    pc_d        = pc_q;
    epc_d       = epc_q;
    addr_err_d  = 1'b0;
    case (pc_src)
      PC_SRC_EXC: begin
        pc_d  = EXC_VECTOR;
        epc_d = exc_pc__i;
      end
      PC_SRC_BRANCH, PC_SRC_JUMP: begin
        pc_d       = tgt_aligned.addr[ADDR_W-1:0];
        addr_err_d = tgt_aligned.err;
      end
      PC_SRC_SEQ:  pc_d = pc_q + ADDR_W'(INSTR_BYTES);
      default:     pc_d = pc_q;
    endcase
  end

  // Upper bits of the widened alignment result are zero extension only.
  if (ADDR_W < MAX_ADDR_W) begin : g_align_hi
    logic unused_align_hi;
    assign unused_align_hi = ^tgt_aligned.addr[MAX_ADDR_W-1:ADDR_W];
  end

  // PC, EPC and alignment-error registers.
  always_ff @(posedge clock__i) begin
    if (reset__i) begin
      pc_q       <= RESET_VECTOR;
      epc_q      <= '0;
      addr_err_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      epc_q      <= epc_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Calls and returns decoded on a path being squashed by EX or an exception are dropped.
  assign ras_push = call__i & ~exc__i & ~branch__i;
  assign ras_pop  = ret__i  & ~exc__i & ~branch__i;

  return_addr_stack #(
    .ADDR_W   (ADDR_W),
    .RAS_DEPTH(RAS_DEPTH)
  ) u_ras (
    .clock__i   (clock__i),
    .reset__i   (reset__i),
    .push_i     (ras_push),
    .pop_i      (ras_pop),
    .push_data_i(call_pc__i + ADDR_W'(INSTR_BYTES)),
    .top_o      (ras_target__o),
    .valid_o    (ras_valid__o)
  );

  assign imem_req__o = ~reset__i & ~stall__i;
  assign pc__o       = pc_q;
  assign epc__o      = epc_q;
  assign addr_err__o = addr_err_q;

endmodule

// File: tb/tb_pc_gen.sv
// Self-checking bench for pc_gen: a reference model pushes expected state into
// a scoreboard queue as each cycle's stimulus is driven; entries are popped and
// compared one cycle later, after the rising edge.
module tb_pc_gen;

  localparam int          ADDR_W = 32;
  localparam logic [31:0] RV     = 32'h0000_0000;
  localparam logic [31:0] EV     = 32'h8000_0180;
  localparam int          DEPTH  = 4;

  logic        clk;
  logic        rst, stall, ack, jump, branch, exc, call, ret;
  logic [31:0] jt, bt, exc_pc, cpc;
  logic        imem_req, ras_valid, addr_err;
  logic [31:0] pc, epc, ras_target;

  pc_gen #(
    .ADDR_W      (ADDR_W),
    .RESET_VECTOR(RV),
    .EXC_VECTOR  (EV),
    .RAS_DEPTH   (DEPTH)
  ) dut (
    .clock__i        (clk),
    .reset__i        (rst),
    .stall__i        (stall),
    .imem_req__o     (imem_req),
    .imem_ack__i     (ack),
    .pc__o           (pc),
    .jump__i         (jump),
    .jump_target__i  (jt),
    .branch__i       (branch),
    .branch_target__i(bt),
    .exc__i          (exc),
    .exc_pc__i       (exc_pc),
    .epc__o          (epc),
    .call__i         (call),
    .call_pc__i      (cpc),
    .ret__i          (ret),
    .ras_target__o   (ras_target),
    .ras_valid__o    (ras_valid),
    .addr_err__o     (addr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, stall, ack, jump, branch, exc, call, ret;
    logic [31:0] jt, bt, exc_pc, cpc;
  } stim_t;

  typedef struct {
    string       tag;
    logic [31:0] pc, epc, rt;
    logic        err, rv;
  } exp_t;

  exp_t        sb_q[$];
  int          checks   = 0;
  int          failures = 0;

  // Reference model state; the RAS is kept as a bounded queue, newest at the back.
  logic [31:0] m_pc, m_epc;
  logic        m_err;
  logic [31:0] m_ras[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s.rst = 1'b0; s.stall = 1'b0; s.ack = 1'b1;
    s.jump = 1'b0; s.branch = 1'b0; s.exc = 1'b0; s.call = 1'b0; s.ret = 1'b0;
    s.jt = '0; s.bt = '0; s.exc_pc = '0; s.cpc = '0;
    return s;
  endfunction

  task automatic model_step(input stim_t s, input string tag);
    exp_t e;
    if (s.rst) begin
      m_pc = RV; m_epc = '0; m_err = 1'b0;
      m_ras.delete();
    end else begin
      m_err = 1'b0;
      if (s.exc) begin
        m_pc = EV; m_epc = s.exc_pc;
      end else if (s.branch) begin
        m_pc = {s.bt[31:2], 2'b00}; m_err = (s.bt[1:0] != 2'b00);
      end else if (s.jump) begin
        m_pc = {s.jt[31:2], 2'b00}; m_err = (s.jt[1:0] != 2'b00);
      end else if (!s.stall && s.ack) begin
        m_pc = m_pc + 32'd4;
      end
      if (!s.exc && !s.branch) begin
        if (s.call && s.ret) begin
          if (m_ras.size() == 0) m_ras.push_back(s.cpc + 32'd4);
          else m_ras[m_ras.size()-1] = s.cpc + 32'd4;
        end else if (s.call) begin
          m_ras.push_back(s.cpc + 32'd4);
          if (m_ras.size() > DEPTH) void'(m_ras.pop_front());
        end else if (s.ret && m_ras.size() > 0) begin
          void'(m_ras.pop_back());
        end
      end
    end
    e.tag = tag; e.pc = m_pc; e.epc = m_epc; e.err = m_err;
    e.rv  = (m_ras.size() > 0);
    e.rt  = (m_ras.size() > 0) ? m_ras[m_ras.size()-1] : 32'h0;
    sb_q.push_back(e);
  endtask

  // One clock: drive on the falling edge, check the combinational request,
  // then compare registered outputs just after the rising edge.
  task automatic cycle(input stim_t s, input string tag);
    exp_t e;
    @(negedge clk);
    rst = s.rst; stall = s.stall; ack = s.ack;
    jump = s.jump; jt = s.jt; branch = s.branch; bt = s.bt;
    exc = s.exc; exc_pc = s.exc_pc; call = s.call; cpc = s.cpc; ret = s.ret;
    #1;
    check({tag, "/req"}, imem_req, !s.rst && !s.stall);
    model_step(s, tag);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check({e.tag, "/pc"},  pc,         e.pc);
    check({e.tag, "/epc"}, epc,        e.epc);
    check({e.tag, "/err"}, addr_err,   e.err);
    check({e.tag, "/rv"},  ras_valid,  e.rv);
    check({e.tag, "/rt"},  ras_target, e.rt);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    stim_t s;
    m_pc = '0; m_epc = '0; m_err = 1'b0;
    rst = 1'b1; stall = 1'b0; ack = 1'b0; jump = 1'b0; branch = 1'b0;
    exc = 1'b0; call = 1'b0; ret = 1'b0;
    jt = '0; bt = '0; exc_pc = '0; cpc = '0;

    // Reset state.
    s = idle(); s.rst = 1'b1;
    cycle(s, "reset");
    check("plan_reset_pc", pc, RV);
    check("plan_reset_rv", ras_valid, 1'b0);

    // Sequential fetch 0 -> 0x20.
    for (int i = 0; i < 4; i++) cycle(idle(), "seq");
    check("plan_seq_10", pc, 32'h10);
    for (int i = 0; i < 4; i++) cycle(idle(), "seq2");
    check("plan_seq_20", pc, 32'h20);

    // Stall holds and drops the request; release resumes.
    s = idle(); s.stall = 1'b1;
    for (int i = 0; i < 3; i++) cycle(s, "stall");
    check("plan_stall_hold", pc, 32'h20);
    cycle(idle(), "stall_rel");
    check("plan_stall_rel", pc, 32'h24);

    // No acknowledge holds with the request still up.
    s = idle(); s.ack = 1'b0;
    for (int i = 0; i < 3; i++) cycle(s, "noack");
    check("plan_noack_hold", pc, 32'h24);
    cycle(idle(), "ack_back");

    // Exception beats branch and jump; a same-cycle call is dropped.
    s = idle(); s.exc = 1'b1; s.exc_pc = 32'h40; s.branch = 1'b1; s.bt = 32'h100;
    s.jump = 1'b1; s.jt = 32'h200; s.call = 1'b1; s.cpc = 32'h300;
    cycle(s, "exc_pri");
    check("plan_exc_pc", pc, EV);
    check("plan_exc_epc", epc, 32'h40);

    // Branch beats jump; a losing misaligned jump is not flagged.
    s = idle(); s.branch = 1'b1; s.bt = 32'h100; s.jump = 1'b1; s.jt = 32'h200;
    cycle(s, "br_pri");
    check("plan_br_pri", pc, 32'h100);
    s = idle(); s.branch = 1'b1; s.bt = 32'h104; s.jump = 1'b1; s.jt = 32'h203;
    cycle(s, "br_over_misjump");
    s = idle(); s.exc = 1'b1; s.exc_pc = 32'h88; s.branch = 1'b1; s.bt = 32'h103;
    cycle(s, "exc_over_misbr");

    // Misaligned branch: forced alignment and a one-cycle error pulse.
    s = idle(); s.branch = 1'b1; s.bt = 32'h1003;
    cycle(s, "br_mis");
    check("plan_br_mis_pc", pc, 32'h1000);
    check("plan_br_mis_err", addr_err, 1'b1);
    cycle(idle(), "after_mis");
    check("plan_err_clear", addr_err, 1'b0);

    // Misaligned jump applied during stall.
    s = idle(); s.stall = 1'b1; s.jump = 1'b1; s.jt = 32'h2002;
    cycle(s, "jmp_mis_stall");
    check("plan_jmp_stall_pc", pc, 32'h2000);

    // Wrap from the top of the address space.
    s = idle(); s.ack = 1'b0; s.branch = 1'b1; s.bt = 32'hFFFF_FFFC;
    cycle(s, "br_top");
    cycle(idle(), "wrap");
    check("plan_wrap", pc, 32'h0);

    // RAS: five calls into four entries.
    for (int k = 1; k <= 5; k++) begin
      s = idle(); s.ack = 1'b0; s.call = 1'b1; s.cpc = 32'(k * 16);
      cycle(s, "call");
    end
    check("plan_ras_full_top", ras_target, 32'h54);
    s = idle(); s.ack = 1'b0; s.ret = 1'b1;
    cycle(s, "ret1");
    check("plan_ret1", ras_target, 32'h44);
    cycle(s, "ret2");
    cycle(s, "ret3");
    check("plan_ret3", ras_target, 32'h24);
    cycle(s, "ret4");
    check("plan_ret4_empty", ras_valid, 1'b0);
    cycle(s, "ret5_empty");

    // Call + ret together on an empty stack.
    s = idle(); s.ack = 1'b0; s.call = 1'b1; s.ret = 1'b1; s.cpc = 32'h60;
    cycle(s, "callret_empty");
    check("plan_callret_top", ras_target, 32'h64);
    check("plan_callret_valid", ras_valid, 1'b1);

    // Wrong-path call/ret are ignored.
    s = idle(); s.branch = 1'b1; s.bt = 32'h500; s.call = 1'b1; s.cpc = 32'h700;
    cycle(s, "call_wrongpath");
    s = idle(); s.exc = 1'b1; s.exc_pc = 32'h40; s.ret = 1'b1;
    cycle(s, "ret_wrongpath");
    check("plan_wrongpath_top", ras_target, 32'h64);

    // Build three entries, then reset mid-stream.
    for (int k = 7; k <= 8; k++) begin
      s = idle(); s.call = 1'b1; s.cpc = 32'(k * 16);
      cycle(s, "call_more");
    end
    check("plan_pre_reset_top", ras_target, 32'h84);
    check("plan_pre_reset_epc", epc, 32'h40);
    s = idle(); s.rst = 1'b1; s.call = 1'b1; s.cpc = 32'h900; s.exc = 1'b1; s.exc_pc = 32'h44;
    cycle(s, "mid_reset");
    check("plan_mid_reset_pc", pc, RV);
    check("plan_mid_reset_rv", ras_valid, 1'b0);
    check("plan_mid_reset_epc", epc, 32'h0);
    cycle(idle(), "post_reset");
    s = idle(); s.ret = 1'b1;
    cycle(s, "post_reset_ret");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
Parametrised next-generation program counter for the 5-stage MIPS core. It holds the fetch PC and selects the next PC from four sources: sequential, jump (ID), branch (EX) and exception. It advances only on an accepted instruction-memory request, and stall holds it. It also captures the EPC on exceptions and contains a small return-address stack (RAS) that predicts JR $ra targets for decode.

Parameters:
ADDR_W, 32, PC and target width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded by reset
EXC_VECTOR, 32'h8000_0180, PC loaded on exception
RAS_DEPTH, 4, RAS entries (power of two, >=2)

Ports:
clock__i  in  1  single clock, rising edge
reset__i  in  1  synchronous, active-high reset
stall__i  in  1  hazard-unit stall; hold PC while high
imem_req__o  out  1  fetch request valid
imem_ack__i  in  1  imem accepts the current request this cycle
pc__o  out  ADDR_W  current fetch address
jump__i  in  1  ID-stage jump redirect
jump_target__i  in  ADDR_W  jump target
branch__i  in  1  EX-stage taken-branch redirect
branch_target__i  in  ADDR_W  branch target
exc__i  in  1  exception redirect
exc_pc__i  in  ADDR_W  PC of the faulting instruction
epc__o  out  ADDR_W  captured exception PC
call__i  in  1  ID decoded JAL/JALR; push
call_pc__i  in  ADDR_W  PC of the call instruction
ret__i  in  1  ID decoded JR $ra; pop
ras_target__o  out  ADDR_W  predicted return address (top of stack)
ras_valid__o  out  1  RAS non-empty
addr_err__o  out  1  one-cycle pulse: applied target was misaligned

Behaviour:
- Clocking: one clock domain. Reset is synchronous and active-high; all state updates on the rising edge of clock__i.
- Reset values: pc__o=RESET_VECTOR, epc__o=0, addr_err__o=0, ras_valid__o=0, ras_target__o=0, RAS count=0.
- imem_req__o = ~reset__i & ~stall__i (combinational). Reset asserted mid-operation overrides everything in that cycle.
- Next-PC priority, highest first:
  - exc__i: PC<=EXC_VECTOR; epc__o<=exc_pc__i.
  - branch__i: PC<=branch_target__i.
  - jump__i: PC<=jump_target__i.
  - stall__i or ~imem_ack__i: hold PC.
  - else: PC<=PC+4 (mod 2^ADDR_W; wraps from all-ones-minus-3 to 0).
- Redirects take effect on the next edge regardless of stall__i and imem_ack__i. A redirect discards the outstanding request.
- Redirect latency: 1 cycle, i.e. pc__o equals the target in the cycle after the redirect is sampled.
- Alignment: an applied jump or branch target with bits[1:0]!=0 loads with bits[1:0] forced to 00 and pulses addr_err__o for one cycle. EXC_VECTOR is never flagged. A lower-priority target that loses arbitration is never flagged.
- epc__o changes only on exc__i.
- RAS:
  - call__i pushes call_pc__i+4. When full, it overwrites the oldest entry (circular); count saturates at RAS_DEPTH.
  - ret__i pops. Pop when empty is ignored and leaves ras_valid__o=0.
  - call__i & ret__i in the same cycle replaces the top entry. Count is unchanged, or becomes 1 if the stack was empty.
  - ras_target__o/ras_valid__o are registered and reflect state after the last edge. ras_target__o=0 when empty.
  - call__i/ret__i are ignored in any cycle where exc__i or branch__i is high (wrong-path decode).
  - The RAS only provides a prediction; decode applies it via jump__i.

Decomposition:
- Package pc_pkg:
  - enum pc_src_e {PC_SRC_SEQ, PC_SRC_JUMP, PC_SRC_BRANCH, PC_SRC_EXC, PC_SRC_HOLD}
  - localparam INSTR_BYTES=4
  - function align_target() returning {aligned addr, err bit}
- Sub-module return_addr_stack (params ADDR_W, RAS_DEPTH; ports push, pop, push_data, top, valid). pc_gen holds the priority mux, PC register and EPC.

Test Plan:
- Reset, then imem_ack__i=1 for 4 cycles -> pc__o 0,4,8,C,10; imem_req__o=1 throughout.
- At PC=0x20, stall__i=1 for 3 cycles -> pc__o stays 0x20 and imem_req__o=0; on release, 0x24 follows. Repeat with imem_ack__i=0 -> PC holds while imem_req__o=1.
- Same cycle: exc__i=1 with exc_pc__i=0x40, branch__i=1 to 0x100, jump__i=1 to 0x200 -> next pc__o=0x8000_0180, epc__o=0x40, addr_err__o=0. Next: branch to 0x100 plus jump to 0x200 -> pc__o=0x100.
- branch__i=1 with target 0x1003 -> pc__o=0x1000 and addr_err__o high for exactly 1 cycle. Starting from PC=0xFFFF_FFFC with ack -> pc__o=0.
- RAS_DEPTH=4: calls at 0x10,0x20,0x30,0x40,0x50 -> top=0x54. Four rets -> 0x44,0x34,0x24 then ras_valid__o=0. A fifth ret is ignored. Simultaneous call(0x60)+ret on an empty stack -> top=0x64, valid=1.
- Assert reset__i mid-stream with RAS holding 3 entries and epc=0x40 -> next cycle pc__o=RESET_VECTOR, ras_valid__o=0, epc__o=0.
